// File: rtl/ack_bus_requester_if.sv
// Handshake bundle between one requester agent and the shared ACK bus top/arbiter.
// The requester drives the request; the arbiter side returns grant and winner broadcast.
interface ack_bus_requester_if;
   logic       ack_req_o;
   logic       ack_ready_i;
   logic [1:0] winner_source_id_i;
   logic       ack_event_i;

   modport master (
      output ack_req_o,
      input  ack_ready_i,
      input  winner_source_id_i,
      input  ack_event_i
   );

   modport slave (
      input  ack_req_o,
      output ack_ready_i,
      output winner_source_id_i,
      output ack_event_i
   );
endinterface

// File: rtl/ack_bus_requester.sv
// Per-source ACK bus agent: queues local ACKs, requests the bus, retires one ACK per win,
// then backs off for HOLDOFF cycles so lower-priority sources get a chance.
module ack_bus_requester #(
   parameter logic [1:0] MY_ID   = 2'b01,
   parameter int         DEPTH   = 4,
   parameter int         HOLDOFF = 1,
   parameter int         TIMEOUT = 16,
   localparam int        CW      = $clog2(DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ack_push,
   ack_bus_requester_if.master    bus,
   output logic [CW-1:0]          pending_o,
   output logic                   ack_sent_o,
   output logic                   busy_o,
   output logic                   starved_o,
   output logic                   overflow_o,
   output logic                   protocol_err_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
   localparam logic [7:0]    TIMEOUT_C  = 8'(TIMEOUT);
   localparam logic [7:0]    HOLD_LAST  = 8'((HOLDOFF > 0) ? (HOLDOFF - 1) : 0);

   state_t          state_q;
   state_t          state_d;
   logic [CW-1:0]   pending_d;
   logic [7:0]      wait_cnt;
   logic [7:0]      hold_cnt;
   logic            my_event;
   logic            win;
   logic            push_ok;
   logic            push_drop;
   logic            proto_hit;
   logic            hold_done;

   // A win needs the grant and a broadcast naming us, and only counts while requesting.
   always_comb begin
      my_event  = bus.ack_event_i && (bus.winner_source_id_i == MY_ID);
      win       = (state_q == REQ) && bus.ack_ready_i && my_event;
      push_ok   = ack_push && ((pending_o != DEPTH_C) || win);
      push_drop = ack_push && !push_ok;
      hold_done = (hold_cnt == HOLD_LAST);
      if (state_q == REQ) begin
         proto_hit = bus.ack_ready_i && !my_event;
      end else begin
         proto_hit = bus.ack_ready_i || my_event;
      end
   end

   // A full queue still takes a push on a winning edge, since one slot frees up.
   always_comb begin
      pending_d = pending_o;
      if (push_ok && !win) begin
         pending_d = pending_o + CW'(1);
      end else if (!push_ok && win) begin
         pending_d = pending_o - CW'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (pending_o != '0) begin
               state_d = REQ;
            end
         end
         REQ: begin
            if (win) begin
               if (HOLDOFF > 0) begin
                  state_d = HOLD;
               end else if (pending_d != '0) begin
                  state_d = REQ;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         HOLD: begin
            if (hold_done) begin
               state_d = (pending_o != '0) ? REQ : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         pending_o      <= '0;
         ack_sent_o     <= 1'b0;
         wait_cnt       <= '0;
         hold_cnt       <= '0;
         starved_o      <= 1'b0;
         overflow_o     <= 1'b0;
         protocol_err_o <= 1'b0;
      end else begin
         state_q    <= state_d;
         pending_o  <= pending_d;
         ack_sent_o <= win;

         if ((state_q == HOLD) && !hold_done) begin
            hold_cnt <= hold_cnt + 8'd1;
         end else begin
            hold_cnt <= '0;
         end

         // Starvation tracks consecutive losing REQ cycles and only a win resets it.
         if (win) begin
            wait_cnt  <= '0;
            starved_o <= 1'b0;
         end else if (state_q == REQ) begin
            if (wait_cnt != TIMEOUT_C) begin
               wait_cnt <= wait_cnt + 8'd1;
            end
            if (wait_cnt == (TIMEOUT_C - 8'd1)) begin
               starved_o <= 1'b1;
            end
         end

         overflow_o     <= overflow_o | push_drop;
         protocol_err_o <= protocol_err_o | proto_hit;
      end
   end

   // Request depends on registered state only, so it cannot glitch with bus inputs.
   always_comb begin
      bus.ack_req_o = (state_q == REQ);
      busy_o        = (state_q != IDLE) || (pending_o != '0);
   end

endmodule

// File: tb/tb_ack_bus_requester.sv
// Scoreboard bench for ack_bus_requester: a cycle model predicts every output after each edge
// and the monitor compares the DUT against the queued predictions.
module tb_ack_bus_requester;

   localparam logic [1:0] MY_ID   = 2'b01;
   localparam int         DEPTH   = 4;
   localparam int         HOLDOFF = 1;
   localparam int         TIMEOUT = 16;
   localparam int         CW      = 3;

   typedef struct {
      logic          req;
      logic [CW-1:0] pend;
      logic          sent;
      logic          busy;
      logic          starved;
      logic          ovf;
      logic          perr;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          ack_push = 1'b0;
   logic [CW-1:0] pending_o;
   logic          ack_sent_o;
   logic          busy_o;
   logic          starved_o;
   logic          overflow_o;
   logic          protocol_err_o;

   ack_bus_requester_if bus ();

   ack_bus_requester #(
      .MY_ID   (MY_ID),
      .DEPTH   (DEPTH),
      .HOLDOFF (HOLDOFF),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .ack_push       (ack_push),
      .bus            (bus),
      .pending_o      (pending_o),
      .ack_sent_o     (ack_sent_o),
      .busy_o         (busy_o),
      .starved_o      (starved_o),
      .overflow_o     (overflow_o),
      .protocol_err_o (protocol_err_o)
   );

   always #5 clk = ~clk;

   int   tests_run    = 0;
   int   tests_failed = 0;
   int   sent_seen    = 0;
   exp_t exp_q[$];

   // Model state: 0 idle, 1 requesting, 2 holdoff
   int m_state = 0;
   int m_pend  = 0;
   int m_wait  = 0;
   int m_hold  = 0;
   bit m_sent  = 1'b0;
   bit m_starved = 1'b0;
   bit m_ovf   = 1'b0;
   bit m_perr  = 1'b0;

   task automatic checkOutput(input string tag, input int got, input int want);
      tests_run++;
      if (got != want) begin
         tests_failed++;
         $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, want);
      end
   endtask

   task automatic modelStep(input bit p, input bit r, input bit e, input logic [1:0] id, input bit rs);
      bit req;
      bit mine;
      bit win;
      int n_pend;
      if (rs) begin
         m_state = 0; m_pend = 0; m_wait = 0; m_hold = 0;
         m_sent = 0; m_starved = 0; m_ovf = 0; m_perr = 0;
         return;
      end
      req  = (m_state == 1);
      mine = e && (id == MY_ID);
      win  = req && r && mine;
      if (req ? (r && !mine) : (r || mine)) m_perr = 1;
      n_pend = m_pend - (win ? 1 : 0);
      if (p) begin
         if (m_pend < DEPTH || win) n_pend++;
         else m_ovf = 1;
      end
      case (m_state)
         0: if (m_pend > 0) m_state = 1;
         1: begin
            if (win) begin
               m_wait = 0;
               m_starved = 0;
               if (HOLDOFF > 0) begin
                  m_state = 2;
                  m_hold = 0;
               end else begin
                  m_state = (n_pend > 0) ? 1 : 0;
               end
            end else begin
               if (m_wait < TIMEOUT) m_wait++;
               if (m_wait == TIMEOUT) m_starved = 1;
            end
         end
         default: begin
            m_hold++;
            if (m_hold >= HOLDOFF) begin
               m_state = (m_pend > 0) ? 1 : 0;
               m_hold = 0;
            end
         end
      endcase
      m_sent = win;
      m_pend = n_pend;
   endtask

   task automatic applyStimulus(input bit p, input bit r, input bit e, input logic [1:0] id, input bit rs);
      exp_t x;
      @(negedge clk);
      rst                    = rs;
      ack_push               = p;
      bus.ack_ready_i        = r;
      bus.ack_event_i        = e;
      bus.winner_source_id_i = id;
      modelStep(p, r, e, id, rs);
      x.req     = (m_state == 1);
      x.pend    = CW'(m_pend);
      x.sent    = m_sent;
      x.busy    = (m_state != 0) || (m_pend != 0);
      x.starved = m_starved;
      x.ovf     = m_ovf;
      x.perr    = m_perr;
      exp_q.push_back(x);
   endtask

   // Grants whenever the model says the request is up, like a lone requester on the bus.
   task automatic serveCycle(input bit p);
      bit g;
      g = (m_state == 1);
      applyStimulus(p, g, g, g ? MY_ID : 2'b00, 1'b0);
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   always @(posedge clk) begin
      exp_t x;
      #1;
      if (ack_sent_o === 1'b1) sent_seen++;
      if (exp_q.size() > 0) begin
         x = exp_q.pop_front();
         checkOutput("ack_req_o",      int'(bus.ack_req_o),   int'(x.req));
         checkOutput("pending_o",      int'(pending_o),       int'(x.pend));
         checkOutput("ack_sent_o",     int'(ack_sent_o),      int'(x.sent));
         checkOutput("busy_o",         int'(busy_o),          int'(x.busy));
         checkOutput("starved_o",      int'(starved_o),       int'(x.starved));
         checkOutput("overflow_o",     int'(overflow_o),      int'(x.ovf));
         checkOutput("protocol_err_o", int'(protocol_err_o),  int'(x.perr));
      end
   end

   initial begin
      bus.ack_ready_i        = 1'b0;
      bus.ack_event_i        = 1'b0;
      bus.winner_source_id_i = 2'b00;

      applyStimulus(0, 0, 0, 2'b00, 1);
      applyStimulus(0, 0, 0, 2'b00, 1);
      applyStimulus(0, 0, 0, 2'b00, 0);
      settle();

      // Single ACK, lone requester
      sent_seen = 0;
      serveCycle(1);
      for (int i = 0; i < 6; i++) serveCycle(0);
      settle();
      checkOutput("single_sent_cnt", sent_seen, 1);

      // Three back-to-back pushes, grant on every request cycle
      sent_seen = 0;
      for (int i = 0; i < 3; i++) serveCycle(1);
      for (int i = 0; i < 12; i++) serveCycle(0);
      settle();
      checkOutput("triple_sent_cnt", sent_seen, 3);

      // Fill past DEPTH with no grant, then push on a winning edge
      for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 2'b00, 0);
      settle();
      checkOutput("full_pending", int'(pending_o), DEPTH);
      checkOutput("full_overflow", int'(overflow_o), 1);
      applyStimulus(1, 1, 1, MY_ID, 0);
      for (int i = 0; i < 16; i++) serveCycle(0);
      applyStimulus(0, 0, 0, 2'b00, 1);

      // Continuous loss to another ID, then a win
      serveCycle(1);
      for (int i = 0; i < 18; i++) applyStimulus(0, 0, 1, 2'b00, 0);
      settle();
      checkOutput("starved_after_loss", int'(starved_o), 1);
      for (int i = 0; i < 3; i++) serveCycle(0);
      settle();
      checkOutput("starved_after_win", int'(starved_o), 0);

      // Grant and own-ID event outside REQ, then grant without event inside REQ
      applyStimulus(0, 0, 0, 2'b00, 1);
      applyStimulus(0, 1, 0, 2'b00, 0);
      applyStimulus(0, 0, 0, 2'b00, 1);
      applyStimulus(0, 0, 1, MY_ID, 0);
      applyStimulus(0, 0, 0, 2'b00, 1);
      serveCycle(1);
      serveCycle(0);
      applyStimulus(0, 1, 0, 2'b00, 0);
      for (int i = 0; i < 4; i++) serveCycle(0);

      // Reset while requesting with two pending
      applyStimulus(0, 0, 0, 2'b00, 1);
      applyStimulus(1, 0, 0, 2'b00, 0);
      applyStimulus(1, 0, 0, 2'b00, 0);
      applyStimulus(0, 0, 0, 2'b00, 0);
      applyStimulus(0, 0, 0, 2'b00, 1);
      applyStimulus(0, 0, 0, 2'b00, 0);

      // Random traffic with occasional resets
      for (int i = 0; i < 300; i++) begin
         bit p;
         bit r;
         bit e;
         bit rs;
         logic [1:0] id;
         p  = ($urandom_range(0, 2) == 0);
         r  = (m_state == 1) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 15) == 0);
         e  = ($urandom_range(0, 1) == 1);
         id = ($urandom_range(0, 2) != 0) ? MY_ID : 2'($urandom_range(0, 3));
         rs = ($urandom_range(0, 63) == 0);
         applyStimulus(p, r, e, id, rs);
      end

      settle();
      checkOutput("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
